// File: rtl/cam_rx_frame_writer_if.sv
// Frame-buffer write port of the camera receive path: one write strobe per pixel byte.
// The master side (cam_rx_frame_writer) drives address, data and strobe.
interface cam_rx_frame_writer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] wAddr;
    logic [DATA_WIDTH-1:0] wData;
    logic                  we;

    modport master (output wAddr, output wData, output we);
    modport slave  (input  wAddr, input  wData, input  we);
endinterface

// File: rtl/cam_rx_frame_writer.sv
// 8N1 UART receiver that writes one pixel per byte into a frame buffer and flags frame completion.
// Optional macro RX_IDLE_TIMEOUT_EN abandons a partial frame after TIMEOUT_CYCLES idle cycles.
module cam_rx_frame_writer #(
    parameter int DATA_WIDTH     = 8,
    parameter int TOTAL_BYTES    = 176 * 240,
    parameter int ADDR_WIDTH     = $clog2(TOTAL_BYTES),
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 frame_ack,
    cam_rx_frame_writer_if.master wr,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * 16);
    localparam int TICK_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0]     DIV_LAST  = TICK_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL_BYTES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {F_IDLE, F_RECV, F_DONE} f_state_t;

    rx_state_t rx_state;
    f_state_t  f_state;

    logic                  rx_meta;
    logic                  rx_sync;
    logic [TICK_W-1:0]     div_cnt;
    logic                  tick;
    logic [3:0]            tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [ADDR_WIDTH-1:0] byte_cnt;
    logic                  byte_ok;
    logic                  byte_bad;
    logic                  timeout_hit;

    // NOTE: non-blocking assignments keep these two flops a true two-stage chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running 16x oversample tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= '0;
                            shift    <= {rx_sync, shift[DATA_WIDTH-1:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) rx_state <= RX_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= '0;
                            rx_state <= RX_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // NOTE: both outputs get a default first so this block cannot infer a latch.
    always_comb begin
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        if (rx_state == RX_STOP && tick && tick_cnt == 4'd15) begin
            byte_ok  = rx_sync;
            byte_bad = !rx_sync;
        end
    end

`ifdef RX_IDLE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || f_state != F_RECV || byte_ok) idle_cnt <= '0;
        else                                       idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: a stalled partial frame waits for more bytes forever.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state    <= F_IDLE;
            byte_cnt   <= '0;
            wr.we      <= 1'b0;
            wr.wAddr   <= '0;
            wr.wData   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr.we <= 1'b0;
            // An ack clears the sticky flags; a same-cycle error still sets them.
            if (frame_ack) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (byte_bad) frame_err <= 1'b1;

            case (f_state)
                F_IDLE, F_RECV: begin
                    if (byte_ok) begin
                        wr.we    <= 1'b1;
                        wr.wAddr <= byte_cnt;
                        wr.wData <= shift;
                        busy     <= 1'b1;
                        if (byte_cnt == ADDR_LAST) begin
                            f_state <= F_DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            f_state  <= F_RECV;
                        end
                    end else if (f_state == F_RECV && timeout_hit) begin
                        byte_cnt  <= '0;
                        f_state   <= F_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
                F_DONE: begin
                    busy <= 1'b0;
                    if (frame_ack) begin
                        f_state    <= F_IDLE;
                        byte_cnt   <= '0;
                        frame_done <= 1'b0;
                    end else begin
                        frame_done <= 1'b1;
                        if (byte_ok) overrun <= 1'b1;
                    end
                end
                default: f_state <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_rx_frame_writer.sv
// Self-checking bench for cam_rx_frame_writer: 16 clocks per bit, 4-byte frames, 400-cycle timeout.
// Write expectations go through a scoreboard queue; status flags are checked from a vector table.
module tb_cam_rx_frame_writer;

    localparam int TOTAL_BYTES = 4;
    localparam int ADDR_WIDTH  = 2;
    localparam int DATA_WIDTH  = 8;
    localparam int BIT_CYCLES  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic frame_ack = 1'b0;
    logic busy, frame_done, frame_err, overrun;

    cam_rx_frame_writer_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) wr ();

    cam_rx_frame_writer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .TOTAL_BYTES   (TOTAL_BYTES),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLK_FREQ      (1_600_000),
        .BAUD_RATE     (100_000),
        .TIMEOUT_CYCLES(400)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .frame_ack (frame_ack),
        .wr        (wr),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    typedef struct {
        bit                    send;
        logic [DATA_WIDTH-1:0] data;
        logic                  stop;
        bit                    ack;
        bit                    exp_wr;
        logic [ADDR_WIDTH-1:0] exp_addr;
        logic                  exp_busy;
        logic                  exp_done;
        logic                  exp_err;
        logic                  exp_ovr;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic b, input logic d, input logic e, input logic o);
        check({tag, "_busy"}, busy, b);
        check({tag, "_done"}, frame_done, d);
        check({tag, "_err"}, frame_err, e);
        check({tag, "_ovr"}, overrun, o);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 character; a bad stop bit is held shorter so it cannot pass for a new start bit.
    task automatic send_byte(input logic [DATA_WIDTH-1:0] d, input logic stop);
        rx = 1'b0;
        wait_cycles(BIT_CYCLES);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rx = d[i];
            wait_cycles(BIT_CYCLES);
        end
        rx = stop;
        wait_cycles(stop ? BIT_CYCLES : 12);
        rx = 1'b1;
        wait_cycles(12);
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        wait_cycles(1);
        frame_ack = 1'b0;
    endtask

    task automatic push_exp(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, wr.we, 1'b0);
        check({tag, "_waddr"}, wr.wAddr, '0);
        check({tag, "_wdata"}, wr.wData, '0);
        check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Write monitor: pops the scoreboard on every strobe.
    logic prev_we  = 1'b0;
    logic done_due = 1'b0;

    always @(negedge clk) begin
        wr_t e;
        if (done_due) begin
            check("frame_done_rise", frame_done, 1'b1);
            done_due = 1'b0;
        end
        if (wr.we === 1'b1) begin
            check("we_not_back_to_back", prev_we, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: got addr %0d data %h expected no write", wr.wAddr, wr.wData);
            end else begin
                e = exp_q.pop_front();
                check("waddr", wr.wAddr, e.addr);
                check("wdata", wr.wData, e.data);
                if (e.addr == ADDR_WIDTH'(TOTAL_BYTES - 1)) begin
                    check("frame_done_with_last_we", frame_done, 1'b0);
                    done_due = 1'b1;
                end
            end
        end
        prev_we = wr.we;
    end

    initial begin
        //            send data   stop ack wr addr busy done err ovr
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h56, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        wait_cycles(3);
        check_all_zero("reset");
        reset = 1'b0;
        wait_cycles(5);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].send) begin
                if (vecs[i].exp_wr) push_exp(vecs[i].exp_addr, vecs[i].data);
                send_byte(vecs[i].data, vecs[i].stop);
            end
            if (vecs[i].ack) pulse_ack();
            wait_cycles(2);
            check_flags($sformatf("v%0d", i), vecs[i].exp_busy, vecs[i].exp_done,
                        vecs[i].exp_err, vecs[i].exp_ovr);
        end

        // Glitch shorter than half a bit is a false start.
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(20);
        check_flags("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(2'd0, 8'h55);
        send_byte(8'h55, 1'b1);
        check("glitch_next_busy", busy, 1'b1);

        // Reset in the middle of a frame and of a byte.
        push_exp(2'd1, 8'h66);
        send_byte(8'h66, 1'b1);
        rx = 1'b0;
        wait_cycles(40);
        reset = 1'b1;
        rx = 1'b1;
        wait_cycles(1);
        check_all_zero("midreset");
        reset = 1'b0;
        wait_cycles(20);
        check_all_zero("after_reset");
        push_exp(2'd0, 8'h99);
        send_byte(8'h99, 1'b1);
        check("post_reset_busy", busy, 1'b1);
        push_exp(2'd1, 8'hAB);
        send_byte(8'hAB, 1'b1);

        // Long idle inside a partial frame.
        wait_cycles(450);
`ifdef RX_IDLE_TIMEOUT_EN
        check_flags("timeout", 1'b0, 1'b0, 1'b1, 1'b0);
        push_exp(2'd0, 8'hC3);
        send_byte(8'hC3, 1'b1);
        check("timeout_next_busy", busy, 1'b1);
`else
        check_flags("no_timeout", 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        check_all_zero("final_reset");
        check("pending_writes", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_rx_frame_writer.md
# cam_rx_frame_writer

Receive-side counterpart of the camera transmit path, located on the image-processing FPGA. It deserialises 8N1 UART bytes from the camera FPGA's `tx` line and writes each byte, one pixel per byte, into a local frame buffer at sequential addresses. When `TOTAL_BYTES` bytes have been written it signals a complete frame, then holds until the downstream consumer acknowledges it.

## Interface
- `DATA_WIDTH`, 8: UART byte and pixel width.
- `TOTAL_BYTES`, 176*240: bytes per frame.
- `ADDR_WIDTH`, $clog2(TOTAL_BYTES): frame-buffer address width.
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate. The oversample divisor is `CLK_FREQ/(BAUD_RATE*16)`, truncated; the default gives 651.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte idle limit. Used only with the macro.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input; idles high.
- `frame_ack` in 1: consumer has finished with the frame; single-cycle pulse.
- `wAddr` out ADDR_WIDTH: frame-buffer write address.
- `wData` out DATA_WIDTH: frame-buffer write data.
- `we` out 1: write strobe, one cycle per byte.
- `busy` out 1: frame reception in progress.
- `frame_done` out 1: full frame stored; level signal.
- `frame_err` out 1: sticky flag for a framing or timeout error.
- `overrun` out 1: sticky flag for a byte dropped while `frame_done` was high.

## Operation
- Input synchroniser: `rx` passes through a 2-FF synchroniser whose flops reset to 1. All logic uses the synchronised bit.
- Tick generator: counts 0..divisor-1 and emits a one-cycle `tick` on wrap. Free-running; resets to 0.
- Receiver FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE → RX_START when the synchronised rx is 0. The tick-count sub-counter clears on this entry.
  - RX_START: after 8 ticks, sample. If 0, go to RX_DATA. If 1, it was a false start; return to RX_IDLE with no other effect.
  - RX_DATA: sample every 16 ticks, LSB first, 8 bits. Then go to RX_STOP.
  - RX_STOP: after 16 ticks, sample. If 1, the byte is valid. If 0, discard the byte and set `frame_err`. Either way return to RX_IDLE.
- Frame FSM, states F_IDLE, F_RECV, F_DONE:
  - F_IDLE: the first valid byte is written at address 0; move to F_RECV and set `busy`=1.
  - F_RECV: each valid byte is written at the current byte counter, and the counter increments.
  - Last byte: the write to address `TOTAL_BYTES-1` moves the FSM to F_DONE.
  - F_DONE: `busy`=0 and `frame_done`=1. Valid bytes arriving here are not written and set `overrun`.
  - Exit from F_DONE: `frame_ack` returns the FSM to F_IDLE. The counter is set to 0, and `frame_done`, `frame_err` and `overrun` all clear.
- `frame_ack` outside F_DONE clears `frame_err` and `overrun` only. It does not change state or the counter.
- Counter: ADDR_WIDTH wide, never exceeds `TOTAL_BYTES-1`, no wrap-around. It is cleared only by reset, `frame_ack` in F_DONE, or timeout.
- A framing error does not advance the counter.

## Timing
- Reset values: all outputs are 0, FSMs are in RX_IDLE/F_IDLE, and the counter and tick divider are 0.
- Write latency: `we`, `wAddr` and `wData` assert in the cycle after the tick on which the stop bit is sampled as 1. They are valid for exactly one cycle.
- The counter increments in the same cycle as `we`, so the next write uses addr+1.
- `frame_done` rises in the cycle after the final `we` and stays high until `frame_ack`. It falls one cycle after `frame_ack` is sampled.
- Simultaneous events:
  - If `frame_ack` and a valid byte coincide in F_DONE, the ack wins and the byte is dropped with `overrun` left clear.
  - If `frame_ack` coincides with an error set outside F_DONE, the set wins.
- Byte rate: at most one byte every 160 ticks, so `we` is never back-to-back.
- Reset mid-byte or mid-frame: the partial byte and frame are abandoned. The next start bit begins a new frame at address 0.

## Configuration
- `RX_IDLE_TIMEOUT_EN` defined: in F_RECV, a counter counts cycles since the last valid byte.
  - On reaching `TIMEOUT_CYCLES`, the byte counter resets to 0, the frame FSM returns to F_IDLE, `busy` goes to 0, and `frame_err` is set.
  - The timeout counter is inactive in F_IDLE and F_DONE.
- `RX_IDLE_TIMEOUT_EN` undefined: there is no timeout logic, and a stalled partial frame waits indefinitely.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=100_000 (divisor 1, 16 cycles/bit), TOTAL_BYTES=4, TIMEOUT_CYCLES=400.
- Frame: send 0xA5, 0x3C, 0xFF, 0x00 → `we` at addr 0..3 with those data, `busy` high from the first write, `frame_done`=1 one cycle after the fourth `we`. Then `frame_ack` → `frame_done`=0 and a new frame writes addr 0.
- Glitch: drive rx low for 4 cycles, then high → no `we`, FSM returns to idle, and a following byte 0x55 is written at addr 0.
- Framing error: send 0x12 with stop bit 0 → no `we`, `frame_err`=1, counter unchanged. The next byte 0x34 lands at the same address.
- Overrun: after `frame_done`, send 0x77 → no `we` and `overrun`=1. Then `frame_ack` → `overrun`=0 and `frame_done`=0.
- Reset mid-frame: send 2 bytes, assert `reset` for 1 cycle → all outputs 0. The next byte is written at addr 0.
- With `RX_IDLE_TIMEOUT_EN`: send 2 bytes, then idle 400 cycles → `frame_err`=1 and `busy`=0. The next byte is written at addr 0. Without the macro the same stimulus leaves `busy`=1.
